// File: rtl/fetch_unit.sv
// CHIP-8 instruction fetch stage: owns the PC, assembles each big-endian 16-bit
// instruction from two byte reads and hands it to decode over valid/ready.
module fetch_unit #(
    parameter logic [11:0] RESET_PC  = 12'h200,
    parameter logic [11:0] LAST_ADDR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    input  logic        redirect_valid,
    input  logic [11:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [15:0] instruction,
    output logic [11:0] pc,
    output logic        fetch_trap
);

    typedef enum logic [2:0] {
        REQ_HI,
        WAIT_HI,
        REQ_LO,
        WAIT_LO,
        HOLD,
        TRAP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] pc_nxt;
    logic [15:0] instr_nxt;
    logic        valid_nxt;
    logic        discard;
    logic        discard_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= REQ_HI;
            pc          <= RESET_PC;
            instruction <= 16'h0000;
            instr_valid <= 1'b0;
            discard     <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruction <= instr_nxt;
            instr_valid <= valid_nxt;
            discard     <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        instr_nxt   = instruction;
        valid_nxt   = instr_valid;
        discard_nxt = discard;
        mem_req     = 1'b0;
        mem_addr    = pc;

        case (state)
            REQ_HI: begin
                if (pc == LAST_ADDR) begin
                    state_nxt = TRAP;
                end else begin
                    mem_req   = 1'b1;
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (mem_rvalid) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                        state_nxt   = REQ_HI;
                    end else begin
                        instr_nxt[15:8] = mem_rdata;
                        state_nxt       = REQ_LO;
                    end
                end
            end
            REQ_LO: begin
                mem_req   = 1'b1;
                mem_addr  = pc + 12'd1;
                state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (mem_rvalid) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                        state_nxt   = REQ_HI;
                    end else begin
                        instr_nxt[7:0] = mem_rdata;
                        valid_nxt      = 1'b1;
                        state_nxt      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (instr_valid && instr_ready) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = pc + 12'd2;
                    state_nxt = REQ_HI;
                end
            end
            TRAP: begin
                state_nxt = TRAP;
            end
            default: begin
                state_nxt = REQ_HI;
            end
        endcase

        // Redirect overrides everything above; an in-flight read must still drain
        // so that only one request is ever outstanding.
        if (redirect_valid && (state != TRAP)) begin
            pc_nxt    = redirect_pc;
            valid_nxt = 1'b0;
            instr_nxt = instruction;
            if ((state == WAIT_HI) || (state == WAIT_LO)) begin
                if (mem_rvalid) begin
                    discard_nxt = 1'b0;
                    state_nxt   = REQ_HI;
                end else begin
                    discard_nxt = 1'b1;
                    state_nxt   = state;
                end
            end else begin
                state_nxt = REQ_HI;
            end
        end

        // The reset state is REQ_HI, so gate the pulse while reset is held.
        if (rst) begin
            mem_req = 1'b0;
        end
    end

    assign fetch_trap = (state == TRAP);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: byte memory model with programmable latency,
// expected {pc, instruction} pairs queued per fetch and checked on instr_valid.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [11:0] pc;
    logic        fetch_trap;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_ready    (instr_ready),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .pc             (pc),
        .fetch_trap     (fetch_trap)
    );

    typedef struct packed {
        logic [11:0] pc;
        logic [15:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem [4096];
    int          n_tests;
    int          n_fail;
    int          n_req;
    int          lat;
    int          pend_cnt;
    logic [11:0] pend_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [11:0] addr);
        exp_t        e;
        logic [11:0] a1;
        a1      = addr + 12'd1;
        e.pc    = addr;
        e.instr = {mem[addr], mem[a1]};
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        chk_eq({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_eq({tag, "_pc"}, pc, e.pc);
            chk_eq({tag, "_instr"}, instruction, e.instr);
            chk_eq({tag, "_valid"}, instr_valid, 1'b1);
        end
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid) seen = 1'b1;
        end
        chk_eq({tag, "_arrived"}, seen, 1'b1);
    endtask

    task automatic accept_one();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    // Memory responder: one pending read, data returned `lat` cycles after the request.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        pend_cnt   = 0;
        pend_addr  = 12'h000;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rst) begin
                pend_cnt = 0;
            end else begin
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem[pend_addr];
                    end
                end
                if (mem_req) begin
                    n_req++;
                    pend_addr = mem_addr;
                    pend_cnt  = lat;
                end
            end
        end
    end

    initial begin
        int  cyc;
        int  req0;
        bit  hit;
        bit  vseen;
        n_tests = 0;
        n_fail  = 0;
        n_req   = 0;
        lat     = 1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h34;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        instr_ready    = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_mem_req", mem_req, 1'b0);
        chk_eq("rst_mem_addr", mem_addr, 12'h200);
        chk_eq("rst_pc", pc, 12'h200);
        chk_eq("rst_valid", instr_valid, 1'b0);
        chk_eq("rst_instr", instruction, 16'h0000);
        chk_eq("rst_trap", fetch_trap, 1'b0);

        // First fetch: four cycles to instr_valid with 1-cycle memory
        push_exp(12'h200);
        #1 rst = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 20 && !instr_valid; i++) begin
            @(posedge clk);
            #1;
            cyc = i;
        end
        chk_eq("first_latency", cyc, 4);
        @(negedge clk);
        pop_cmp("f200");

        // Back-pressure: nothing moves, no requests
        req0 = n_req;
        repeat (10) @(negedge clk);
        chk_eq("stall_req", n_req - req0, 0);
        chk_eq("stall_instr", instruction, 16'h1234);
        chk_eq("stall_pc", pc, 12'h200);
        chk_eq("stall_valid", instr_valid, 1'b1);

        accept_one();
        chk_eq("next_req", mem_req, 1'b1);
        chk_eq("next_addr", mem_addr, 12'h202);
        push_exp(12'h202);
        wait_valid("f202");
        pop_cmp("f202");

        // Redirect while the low byte is outstanding
        lat = 3;
        accept_one();
        push_exp(12'h204);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 12'h205) hit = 1'b1;
        end
        chk_eq("lo_req_seen", hit, 1'b1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 12'h300;
        exp_q.delete();
        @(negedge clk);
        redirect_valid = 1'b0;
        lat = 1;
        chk_eq("wlo_redir_pc", pc, 12'h300);
        chk_eq("wlo_redir_valid", instr_valid, 1'b0);
        hit   = 1'b0;
        vseen = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (instr_valid) vseen = 1'b1;
            if (mem_req) hit = 1'b1;
        end
        chk_eq("wlo_req_seen", hit, 1'b1);
        chk_eq("wlo_req_addr", mem_addr, 12'h300);
        chk_eq("wlo_no_stale", vseen, 1'b0);
        push_exp(12'h300);
        wait_valid("f300");
        pop_cmp("f300");

        // Redirect and ready together in HOLD: redirect wins
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFE;
        instr_ready    = 1'b1;
        exp_q.delete();
        @(negedge clk);
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        chk_eq("hold_redir_pc", pc, 12'hFFE);
        chk_eq("hold_redir_valid", instr_valid, 1'b0);
        push_exp(12'hFFE);
        wait_valid("fFFE");
        pop_cmp("fFFE");

        // PC wraps from 0xFFE to 0x000
        accept_one();
        chk_eq("wrap_req", mem_req, 1'b1);
        chk_eq("wrap_addr", mem_addr, 12'h000);
        chk_eq("wrap_pc", pc, 12'h000);
        push_exp(12'h000);
        wait_valid("f000");
        pop_cmp("f000");

        // Trap on the last address; sticky until reset
        chk_eq("pre_trap", fetch_trap, 1'b0);
        req0 = n_req;
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFF;
        exp_q.delete();
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("trap_set", fetch_trap, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 12'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk_eq("trap_no_req", n_req - req0, 0);
        chk_eq("trap_pc", pc, 12'hFFF);
        chk_eq("trap_sticky", fetch_trap, 1'b1);
        chk_eq("trap_valid", instr_valid, 1'b0);

        // Reset clears the trap and fetching restarts
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        chk_eq("rerst_trap", fetch_trap, 1'b0);
        push_exp(12'h200);
        wait_valid("r200");
        pop_cmp("r200");

        // Asynchronous reset in the middle of WAIT_HI
        lat = 3;
        accept_one();
        chk_eq("mid_req_addr", mem_addr, 12'h202);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk_eq("async_mem_req", mem_req, 1'b0);
        chk_eq("async_mem_addr", mem_addr, 12'h200);
        chk_eq("async_pc", pc, 12'h200);
        chk_eq("async_valid", instr_valid, 1'b0);
        chk_eq("async_instr", instruction, 16'h0000);
        chk_eq("async_trap", fetch_trap, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        lat = 1;
        push_exp(12'h200);
        wait_valid("a200");
        pop_cmp("a200");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
